// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO and paced by an oversampling tick.
// Data width, parity and stop-bit count are set by parameters.
`timescale 1ns/1ps
module uart_tx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        s_tick,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx,
  output logic                        transmit_active,
  output logic                        transmit_over,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic [CW-1:0]    FULL      = CW'(FIFO_DEPTH);
  localparam logic             ODD       = (PARITY_MODE == 2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 act_q, act_d;
  logic                 over_q, over_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head;
  logic                 push, pop;

  assign tx_ready        = (count_q != FULL);
  assign push            = tx_valid && tx_ready;
  assign head            = mem_q[rd_ptr_q];
  assign tx              = tx_q;
  assign transmit_active = act_q;
  assign transmit_over   = over_q;
  assign fifo_count      = count_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    act_d   = act_q;
    over_d  = 1'b0;
    pop     = 1'b0;
    if (s_tick) begin
      if (state_q == S_IDLE) begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
          par_d   = (^head) ^ ODD;
          cnt_d   = '0;
          idx_d   = '0;
          act_d   = 1'b1;
          state_d = S_START;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          case (state_q)
            S_START: state_d = S_DATA;
            S_DATA: begin
              shift_d = shift_q >> 1;
              if (idx_q == DATA_LAST) begin
                idx_d   = '0;
                state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
            S_PARITY: state_d = S_STOP;
            S_STOP: begin
              if (idx_q == STOP_LAST) begin
                idx_d   = '0;
                state_d = S_IDLE;
                over_d  = 1'b1;
                // Stay active when a queued word will reload on the next tick.
                act_d   = (count_q != '0);
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
    end

    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      tx_q     <= 1'b1;
      act_q    <= 1'b0;
      over_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      tx_q     <= tx_d;
      act_q    <= act_d;
      over_q   <= over_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Datapath storage carries no reset; the control count guards its validity.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    par_q   <= par_d;
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame tables per configuration, a queued-word scoreboard
// for back-to-back frames, and reset corner sequences.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       tick, tick_f;
  logic [7:0] data;
  logic [4:0] data_f;
  logic       valid_a, valid_p, valid_o, valid_f;
  logic       ready_a, ready_p, ready_o, ready_f;
  logic       tx_a, tx_p, tx_o, tx_f;
  logic       act_a, act_p, act_o, act_f;
  logic       over_a, over_p, over_o, over_f;
  logic [2:0] cnt_a, cnt_p, cnt_o, cnt_f;

  int n_cmp  = 0;
  int n_fail = 0;
  int ph     = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;
  vec_t vecs[5];

  uart_tx_fifo u_a (
    .clk(clk), .rst_n(rst_n), .s_tick(tick), .tx_data(data), .tx_valid(valid_a),
    .tx_ready(ready_a), .tx(tx_a), .transmit_active(act_a), .transmit_over(over_a),
    .fifo_count(cnt_a));

  uart_tx_fifo #(.PARITY_MODE(1), .STOP_BITS(2)) u_p (
    .clk(clk), .rst_n(rst_n), .s_tick(tick), .tx_data(data), .tx_valid(valid_p),
    .tx_ready(ready_p), .tx(tx_p), .transmit_active(act_p), .transmit_over(over_p),
    .fifo_count(cnt_p));

  uart_tx_fifo #(.PARITY_MODE(2), .STOP_BITS(2)) u_o (
    .clk(clk), .rst_n(rst_n), .s_tick(tick), .tx_data(data), .tx_valid(valid_o),
    .tx_ready(ready_o), .tx(tx_o), .transmit_active(act_o), .transmit_over(over_o),
    .fifo_count(cnt_o));

  uart_tx_fifo #(.DATA_BITS(5)) u_f (
    .clk(clk), .rst_n(rst_n), .s_tick(tick_f), .tx_data(data_f), .tx_valid(valid_f),
    .tx_ready(ready_f), .tx(tx_f), .transmit_active(act_f), .transmit_over(over_f),
    .fifo_count(cnt_f));

  // Tick for the 5-bit instance: one clk in every four.
  initial begin
    tick_f = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_f = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic get_tx(input int w);
    case (w)
      0: return tx_a;
      1: return tx_p;
      2: return tx_o;
      default: return tx_f;
    endcase
  endfunction

  function automatic logic get_act(input int w);
    case (w)
      0: return act_a;
      1: return act_p;
      2: return act_o;
      default: return act_f;
    endcase
  endfunction

  function automatic logic get_over(input int w);
    case (w)
      0: return over_a;
      1: return over_p;
      2: return over_o;
      default: return over_f;
    endcase
  endfunction

  // Entered at the sample just after the load edge; leaves at the final stop tick sample.
  task automatic check_frame(input int w, input int nb, input logic [15:0] frame,
                             input int cpb, input logic more, input string tag);
    int   n, over_cnt, act_bad;
    logic exp_b, got_b;
    n = nb * cpb;
    over_cnt = 0;
    act_bad = 0;
    got_b = 1'b0;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        exp_b = frame[i / cpb];
        if (i % cpb == 0) got_b = exp_b;
        if (get_tx(w) !== exp_b) got_b = get_tx(w);
        if (get_act(w) !== 1'b1) act_bad++;
        if (get_over(w) !== 1'b0) over_cnt++;
        if (i % cpb == cpb - 1)
          chk($sformatf("%s bit%0d", tag, i / cpb), 32'(got_b), 32'(exp_b));
        step();
      end else begin
        chk({tag, " tx after stop"}, 32'(get_tx(w)), 32'd1);
        chk({tag, " transmit_over at end"}, 32'(get_over(w)), 32'd1);
        chk({tag, " active at end"}, 32'(get_act(w)), 32'(more));
      end
    end
    chk({tag, " active inside frame"}, 32'(act_bad), 32'd0);
    chk({tag, " early transmit_over"}, 32'(over_cnt), 32'd0);
  endtask

  task automatic push_wait(input int w, input logic [7:0] word, input string tag);
    int lat;
    data = word;
    case (w)
      0: valid_a = 1'b1;
      1: valid_p = 1'b1;
      default: valid_o = 1'b1;
    endcase
    step();
    valid_a = 1'b0;
    valid_p = 1'b0;
    valid_o = 1'b0;
    lat = 0;
    while (get_tx(w) !== 1'b0 && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, " push-to-start latency"}, 32'(lat), 32'd1);
  endtask

  initial begin
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h81, 10'b1100000010};

    rst_n = 1'b0; tick = 1'b1; data = 8'h77; data_f = '0;
    valid_a = 1'b1; valid_p = 1'b0; valid_o = 1'b0; valid_f = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("reset tx", 32'(tx_a), 32'd1);
      chk("reset fifo_count", 32'(cnt_a), 32'd0);
      chk("reset tx_ready", 32'(ready_a), 32'd1);
      chk("reset transmit_over", 32'(over_a), 32'd0);
    end
    valid_a = 1'b0;
    rst_n = 1'b1;
    step(); step();

    for (int k = 0; k < 5; k++) begin
      push_wait(0, vecs[k].data, $sformatf("8N1 %02h", vecs[k].data));
      check_frame(0, 10, 16'(vecs[k].frame), 16, 1'b0, $sformatf("8N1 %02h", vecs[k].data));
      step(); step();
    end

    push_wait(1, 8'hA5, "8E2 A5");
    check_frame(1, 12, 16'h0D4A, 16, 1'b0, "8E2 A5");
    step(); step();
    push_wait(2, 8'hA5, "8O2 A5");
    check_frame(2, 12, 16'h0F4A, 16, 1'b0, "8O2 A5");
    step(); step();

    begin : slow_tick
      int lat;
      data_f = 5'h13; valid_f = 1'b1;
      step();
      valid_f = 1'b0;
      lat = 0;
      while (tx_f !== 1'b0 && lat < 20) begin
        step();
        lat++;
      end
      chk("5N1 load within one tick period", 32'(lat >= 1 && lat <= 4), 32'd1);
      check_frame(3, 7, 16'b0000000001100110, 64, 1'b0, "5N1 13");
    end
    step(); step();

    fork
      begin : pusher
        logic acc;
        for (int v = 1; v <= 5; v++) begin
          data = 8'(v);
          valid_a = 1'b1;
          acc = 1'b0;
          for (int g = 0; g < 400 && !acc; g++) begin
            acc = ready_a;
            step();
          end
          if (acc) exp_q.push_back(8'(v));
        end
        valid_a = 1'b0;
        chk("b2b tx_ready low when full", 32'(ready_a), 32'd0);
      end
      begin : monitor
        int g;
        logic [7:0]  w;
        logic [15:0] fr;
        g = 0;
        while (tx_a !== 1'b0 && g < 50) begin
          step();
          g++;
        end
        chk("b2b first load seen", 32'(tx_a), 32'd0);
        for (int k = 0; k < 5; k++) begin
          if (exp_q.size() == 0) begin
            chk("b2b scoreboard has word", 32'd0, 32'd1);
            w = 8'h00;
          end else begin
            w = exp_q.pop_front();
          end
          fr = {6'b0, 1'b1, w, 1'b0};
          if (k >= 1) begin
            chk($sformatf("b2b fifo_count at frame %0d", k + 1), 32'(cnt_a), 32'(4 - k));
            if (k == 1) chk("b2b tx_ready after 0x02 pops", 32'(ready_a), 32'd1);
          end
          check_frame(0, 10, fr, 16, (k < 4), $sformatf("b2b frame %0d", k + 1));
          if (k == 0) chk("b2b tx_ready at end of frame 1", 32'(ready_a), 32'd0);
          if (k < 4) step();
        end
      end
    join
    step(); step();

    begin : mid_reset
      int bad;
      data = 8'h5A; valid_a = 1'b1;
      step();
      data = 8'h33;
      step();
      data = 8'h66;
      step();
      valid_a = 1'b0;
      for (int c = 0; c < 55; c++) step();
      chk("midreset tx in data bit", 32'(tx_a), 32'd0);
      chk("midreset words queued", 32'(cnt_a), 32'd2);
      rst_n = 1'b0;
      step();
      chk("midreset tx", 32'(tx_a), 32'd1);
      chk("midreset fifo_count", 32'(cnt_a), 32'd0);
      chk("midreset active", 32'(act_a), 32'd0);
      chk("midreset transmit_over", 32'(over_a), 32'd0);
      rst_n = 1'b1;
      bad = 0;
      for (int c = 0; c < 400; c++) begin
        step();
        if (tx_a !== 1'b1 || over_a !== 1'b0 || act_a !== 1'b0) bad++;
      end
      chk("midreset line stays idle", 32'(bad), 32'd0);
      push_wait(0, 8'hC3, "post-reset C3");
      check_frame(0, 10, 16'b0000001110000110, 16, 1'b0, "post-reset C3");
    end

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter that serialises words from a small internal FIFO onto a single `tx` line, paced by an oversampling tick enable. It supersedes the fixed 8-bit, tick-clocked transmitter. It adds configurable data width, optional parity, one or two stop bits, LSB-first ordering, a valid/ready write port and synchronous reset. It sits between the down-sampler/processor output stage and the board UART pin, sharing the baud generator's `s_tick` with the receiver.

## Interface
Parameters:
- `DATA_BITS`, 8: data bits per frame, legal 5–9.
- `OVERSAMPLE`, 16: `s_tick` pulses per bit time, legal 2–256.
- `PARITY_MODE`, 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, 1: legal 1 or 2.
- `FIFO_DEPTH`, 4: word entries, power of two, ≥2.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `s_tick`  in  1  baud×OVERSAMPLE enable, one `clk` wide.
- `tx_data`  in  DATA_BITS  word to send.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  FIFO can accept (= not full).
- `tx`  out  1  serial line, idle high.
- `transmit_active`  out  1  high from frame load through the last stop tick.
- `transmit_over`  out  1  one-`clk` pulse when a frame's last stop bit completes.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  entries held.

## Operation
- Write: the word is pushed on any `clk` edge with `tx_valid && tx_ready`. `tx_ready = (fifo_count != FIFO_DEPTH)`, combinational from registered count. No push while full; data is held, not dropped.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `tx`=1. On an edge with `s_tick`=1 and FIFO non-empty, pop the head into the shift register, compute parity, clear tick counter and bit index, and go to START.
- START: `tx`=0 for OVERSAMPLE ticks.
- DATA: `tx` = shift[0]; shift right every OVERSAMPLE ticks. DATA_BITS bits are sent LSB first.
- PARITY: present only if PARITY_MODE≠0. `tx` = XOR of data (even) or its inverse (odd), for one bit time.
- STOP: `tx`=1 for STOP_BITS×OVERSAMPLE ticks.
- After STOP, go to IDLE and pulse `transmit_over`. The next frame may load on the very next `s_tick` if the FIFO is non-empty, so back-to-back frames have no extra idle bit.
- Tick counter: width clog2(OVERSAMPLE), or 8 bits for OVERSAMPLE=256. It advances only on `s_tick`; on a terminal count it wraps to 0 and the state/bit advances.
- Push and pop on the same edge: count unchanged, both take effect. Pointers wrap modulo FIFO_DEPTH.
- `s_tick` low: every counter and state frozen, `tx` held. FIFO writes still accepted.
- Unused upper `tx_data` bits: none; the width equals DATA_BITS exactly.

## Timing
- Reset (`rst_n`=0 at an edge): `tx`=1, `transmit_active`=0, `transmit_over`=0, `fifo_count`=0, `tx_ready`=1, state IDLE, pointers and counters 0.
- Reset mid-frame aborts the frame: `tx` is 1 after that edge and FIFO contents are discarded.
- All outputs are registered except `tx_ready`.
- Frame length = (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) × OVERSAMPLE ticks, counted from the load tick.
- `tx` falls on the load edge (start bit begins there).
- `transmit_active` rises on the load edge and falls on the edge of the final stop tick. It stays high across a back-to-back reload.
- `transmit_over` is high for exactly the one `clk` after the final stop tick edge.
- Push-to-first-`tx` fall latency from empty/idle: one `clk` for FIFO write, then the next `s_tick` edge.

## Test plan
- Reset defaults: `rst_n`=0 for 3 clk with `tx_valid`=1 → `tx`=1, `fifo_count`=0, `tx_ready`=1, `transmit_over`=0 throughout.
- Defaults (8N1, OVERSAMPLE=16), `s_tick` every clk, push 0xA5 → `tx` = 0 for 16 clk, then 1,0,1,0,0,1,0,1 at 16 clk each, then 1 for 16. `transmit_over` pulses once, 160 clk after load.
- PARITY_MODE=1 then 2, STOP_BITS=2, push 0xA5 → parity bit 0 (even) / 1 (odd), stop high for 32 ticks, frame = 192 ticks.
- FIFO full, FIFO_DEPTH=4: push 0x01..0x05 continuously → 0x01 loads, 0x02–0x05 fill the FIFO, `tx_ready`=0 until 0x02 pops. All five frames go out back-to-back, in order, with no idle bit between stop and start.
- DATA_BITS=5, `s_tick` every 4th clk, push 0x13 → bits 1,1,0,0,1, each lasting 64 clk. Nothing advances between ticks.
- Reset asserted in the middle of the 3rd data bit with 2 words queued → `tx`=1 next clk, `fifo_count`=0. No `transmit_over`, and no further frame without a new push.
